// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port arbiter: merges ALU and buffered LSU results into one
// registered write per cycle and tracks outstanding destinations in a busy vector.
module rf_writeback_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic [4:0]      A3,
    output logic            WE3,
    output logic [XLEN-1:0] WD3,
    output logic [31:0]     busy,
    output logic            fifo_full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_FIFO,
        SRC_BYP
    } src_t;

    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];

    src_t            src;
    logic [4:0]      c_rd;
    logic [XLEN-1:0] c_data;
    logic            push;
    logic            pop;
    logic            wr;
    logic            full;
    logic [31:0]     busy_nxt;

    assign full      = (count == CW'(DEPTH));
    assign fifo_full = full;
    assign alu_ready = ~rst & ~full;
    assign lsu_ready = ~rst & ~full;

    // A full FIFO preempts the ALU so loads can never be starved indefinitely.
    always_comb begin
        src = SRC_NONE;
        if (full)
            src = SRC_FIFO;
        else if (alu_valid)
            src = SRC_ALU;
        else if (count != '0)
            src = SRC_FIFO;
        else if (lsu_valid)
            src = SRC_BYP;
    end

    always_comb begin
        c_rd   = '0;
        c_data = '0;
        case (src)
            SRC_ALU: begin
                c_rd   = alu_rd;
                c_data = alu_data;
            end
            SRC_FIFO: begin
                c_rd   = mem_rd[rd_ptr];
                c_data = mem_data[rd_ptr];
            end
            SRC_BYP: begin
                c_rd   = lsu_rd;
                c_data = lsu_data;
            end
            default: ;
        endcase
    end

    assign push = lsu_valid & lsu_ready & (src != SRC_BYP);
    assign pop  = (src == SRC_FIFO);
    assign wr   = (src != SRC_NONE) & (c_rd != 5'd0);

    // Set is applied after clear so a same-edge reissue keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wr)
            busy_nxt[c_rd] = 1'b0;
        if (iss_valid && iss_rd != 5'd0)
            busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= lsu_rd;
            mem_data[wr_ptr] <= lsu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            A3     <= '0;
            WE3    <= 1'b0;
            WD3    <= '0;
            busy   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            WE3 <= wr;
            if (wr) begin
                A3  <= c_rd;
                WD3 <= c_data;
            end
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Randomized and directed bench for rf_writeback_ctrl, checked against a
// queue-based reference model of the commit priority rules and scoreboard.
module tb_rf_writeback_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid, lsu_valid, iss_valid;
    logic [4:0]      alu_rd, lsu_rd, iss_rd;
    logic [XLEN-1:0] alu_data, lsu_data;
    logic            alu_ready, lsu_ready, WE3, fifo_full;
    logic [4:0]      A3;
    logic [XLEN-1:0] WD3;
    logic [31:0]     busy;

    rf_writeback_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .A3(A3), .WE3(WE3), .WD3(WD3), .busy(busy), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] d;
    } ent_t;

    ent_t            q[$];
    logic [31:0]     mbusy;
    bit              e_we;
    logic [4:0]      e_a;
    logic [XLEN-1:0] e_d;
    int              n_cmp = 0;
    int              n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mbusy = '0;
        e_we  = 1'b0;
        e_a   = '0;
        e_d   = '0;
    endtask

    // Called just after a falling edge: drive one cycle, predict, then check outputs.
    task automatic step(input bit av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                        input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld,
                        input bit iv, input logic [4:0] ird, output bit a_acc);
        ent_t c;
        bit   has;
        int   n;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        iss_valid = iv; iss_rd = ird;
        n = q.size();
        check("alu_ready", 64'(alu_ready), 64'(n < DEPTH));
        check("lsu_ready", 64'(lsu_ready), 64'(n < DEPTH));
        check("fifo_full", 64'(fifo_full), 64'(n == DEPTH));
        a_acc = 1'b0;
        has   = 1'b0;
        c.rd  = '0;
        c.d   = '0;
        if (n == DEPTH) begin
            c = q.pop_front(); has = 1'b1;
        end else if (av) begin
            c.rd = ard; c.d = ad; has = 1'b1; a_acc = 1'b1;
            if (lv) q.push_back('{lrd, ld});
        end else if (n > 0) begin
            c = q.pop_front(); has = 1'b1;
            if (lv) q.push_back('{lrd, ld});
        end else if (lv) begin
            c.rd = lrd; c.d = ld; has = 1'b1;
        end
        e_we = has && (c.rd != 5'd0);
        if (e_we) begin
            e_a = c.rd; e_d = c.d;
            mbusy[c.rd] = 1'b0;
        end
        if (iv && ird != 5'd0) mbusy[ird] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("WE3", 64'(WE3), 64'(e_we));
        check("busy", 64'(busy), 64'(mbusy));
        if (e_we) begin
            check("A3", 64'(A3), 64'(e_a));
            check("WD3", 64'(WD3), 64'(e_d));
        end
    endtask

    task automatic idle();
        bit dummy;
        step(0, 0, 0, 0, 0, 0, 0, 0, dummy);
    endtask

    initial begin
        bit acc;
        int ai;
        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        iss_valid = 0; iss_rd = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_WE3", 64'(WE3), 64'd0);
        check("rst_A3", 64'(A3), 64'd0);
        check("rst_WD3", 64'(WD3), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_alu_ready", 64'(alu_ready), 64'd0);
        check("rst_lsu_ready", 64'(lsu_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(alu_ready), 64'd1);

        // ALU only
        step(1, 5'd5, 32'h0000_00AA, 0, 0, 0, 0, 0, acc);
        check("alu_only_WE3", 64'(WE3), 64'd1);
        check("alu_only_A3", 64'(A3), 64'd5);
        check("alu_only_WD3", 64'(WD3), 64'hAA);
        idle();
        check("alu_only_WE3_off", 64'(WE3), 64'd0);

        // LSU bypass with empty FIFO
        step(0, 0, 0, 1, 5'd7, 32'hDEAD_BEEF, 0, 0, acc);
        check("byp_A3", 64'(A3), 64'd7);
        check("byp_WD3", 64'(WD3), 64'hDEAD_BEEF);
        check("byp_not_queued", 64'(fifo_full), 64'd0);
        idle();

        // Contention: four cycles of ALU+LSU fill the FIFO
        for (int i = 1; i <= 4; i++)
            step(1, 5'(i), 32'h100 + 32'(i), 1, 5'(9 + i), 32'h200 + 32'(i), 0, 0, acc);
        check("cont_full", 64'(fifo_full), 64'd1);
        check("cont_alu_ready", 64'(alu_ready), 64'd0);
        check("cont_lsu_ready", 64'(lsu_ready), 64'd0);
        ai = 5;
        step(1, 5'(ai), 32'h100 + 32'(ai), 0, 0, 0, 0, 0, acc);
        check("cont_head_A3", 64'(A3), 64'd10);
        check("cont_head_WD3", 64'(WD3), 64'h201);
        if (acc) ai++;
        for (int k = 0; k < 30 && (ai <= 8 || q.size() != 0); k++) begin
            step(ai <= 8, 5'(ai), 32'h100 + 32'(ai), 0, 0, 0, 0, 0, acc);
            if (acc) ai++;
        end
        check("cont_drained", 64'(q.size()), 64'd0);
        idle();

        // Scoreboard set / clear / same-edge set wins
        step(0, 0, 0, 0, 0, 0, 1, 5'd3, acc);
        check("sb_set", 64'(busy[3]), 64'd1);
        step(1, 5'd3, 32'h33, 0, 0, 0, 0, 0, acc);
        check("sb_clear", 64'(busy[3]), 64'd0);
        step(0, 0, 0, 0, 0, 0, 1, 5'd3, acc);
        step(1, 5'd3, 32'h34, 0, 0, 0, 1, 5'd3, acc);
        check("sb_set_wins", 64'(busy[3]), 64'd1);

        // x0 results and issues
        step(1, 5'd0, 32'h1234, 0, 0, 0, 0, 0, acc);
        check("x0_accepted", 64'(acc), 64'd1);
        check("x0_no_write", 64'(WE3), 64'd0);
        step(0, 0, 0, 0, 0, 0, 1, 5'd0, acc);
        check("x0_busy0", 64'(busy[0]), 64'd0);

        // Async reset with three queued loads and busy = 0x408
        step(1, 5'd20, 32'h20, 1, 5'd1, 32'h51, 1, 5'd3, acc);
        step(1, 5'd21, 32'h21, 1, 5'd2, 32'h52, 1, 5'd10, acc);
        step(1, 5'd22, 32'h22, 1, 5'd4, 32'h54, 0, 0, acc);
        check("mid_busy_pre", 64'(busy), 64'h408);
        check("mid_WE3_pre", 64'(WE3), 64'd1);
        alu_valid = 0; lsu_valid = 0; iss_valid = 0;
        #2 rst = 1'b1;
        #1;
        check("mid_WE3_async", 64'(WE3), 64'd0);
        check("mid_busy_async", 64'(busy), 64'd0);
        check("mid_full_async", 64'(fifo_full), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("mid_lsu_ready", 64'(lsu_ready), 64'd1);
        check("mid_A3", 64'(A3), 64'd0);
        check("mid_WD3", 64'(WD3), 64'd0);
        idle();
        idle();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 99) < 55, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 99) < 40, 5'($urandom_range(0, 31)), acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
- Producer side of the register-file write port: merges results from the single-cycle ALU path and the variable-latency load/store unit (LSU) into the one write port per cycle (A3/WE3/WD3).
- Buffers LSU results in a small FIFO and drives registered write strobes.
- Maintains a pending-write scoreboard (busy vector) that the issue/hazard logic uses to stall readers of in-flight destinations.

Parameters:
- DEPTH, 4, number of LSU result FIFO entries (power of two, ≥2)
- XLEN, 32, data width of results and WD3

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU result present this cycle
- alu_rd  input  5  ALU destination register
- alu_data  input  XLEN  ALU result
- alu_ready  output  1  ALU result accepted when alu_valid & alu_ready
- lsu_valid  input  1  load result present
- lsu_rd  input  5  load destination register
- lsu_data  input  XLEN  load result
- lsu_ready  output  1  load result accepted when lsu_valid & lsu_ready
- iss_valid  input  1  instruction issued with a register destination
- iss_rd  input  5  destination of the issued instruction
- A3  output  5  register-file write address (registered)
- WE3  output  1  register-file write enable (registered)
- WD3  output  XLEN  register-file write data (registered)
- busy  output  32  busy[i]=1 while a write to x[i] is outstanding (registered)
- fifo_full  output  1  LSU FIFO holds DEPTH entries (combinational from count)

Behaviour:
- Reset (async, rst=1): A3=0, WE3=0, WD3=0, busy=0, FIFO count=0, read/write pointers=0. While rst=1, alu_ready=0 and lsu_ready=0.
- alu_ready = lsu_ready = (count < DEPTH), combinational from registered count.
- Commit selection, exactly one source per cycle, in priority order:
  1. count==DEPTH → FIFO head (drain to prevent LSU starvation).
  2. alu_valid → ALU.
  3. count>0 → FIFO head.
  4. lsu_valid & count==0 → LSU direct bypass; the result is not pushed.
- FIFO push: lsu_valid & lsu_ready and LSU not taken by bypass. Push and pop in the same cycle is legal; count is unchanged. Pointers wrap modulo DEPTH.
- Write registers: the commit chosen in cycle N appears on A3/WD3 with WE3=1 in cycle N+1. With no commit, WE3=0 and A3/WD3 hold their previous values.
- x0 handling: a committed result with rd=0 is consumed (handshake completes, FIFO pops) but WE3=0 and busy is not affected.
- Scoreboard:
  - Set: busy[iss_rd] ←1 on iss_valid with iss_rd≠0.
  - Clear: busy[A_commit] ←0 on the edge that asserts WE3 for that address.
  - Same-edge set and clear on the same index: set wins, because the newer producer is outstanding.
  - busy[0] is constant 0.
  - The block does not check that a result matches a prior issue. A commit to a non-busy register still writes and leaves busy=0.
- Ordering: ALU results are never reordered among themselves, and LSU results are never reordered among themselves (FIFO order). Ordering between an ALU result and an LSU result to the same rd is the issue logic's responsibility, enforced via busy.
- Reset mid-operation: FIFO contents are discarded, busy is cleared, and WE3 drops immediately (asynchronously). No write occurs on the first edge after rst deasserts unless a new commit is selected in that cycle.

Test Plan:
- ALU only: alu_valid=1, alu_rd=5, alu_data=0x0000_00AA in cycle N → cycle N+1 WE3=1, A3=5, WD3=0xAA; cycle N+2 WE3=0.
- LSU bypass: FIFO empty, alu_valid=0, lsu_valid=1, lsu_rd=7, lsu_data=0xDEAD_BEEF → next cycle WE3=1, A3=7, WD3=0xDEADBEEF; count remains 0.
- Contention and fill: alu_valid=1 continuously with rd=1..8, lsu_valid=1 with rd=10..13 for 4 cycles.
  - FIFO reaches full and fifo_full=1; alu_ready=0 and lsu_ready=0.
  - The next commit is the head, rd=10.
  - Loads then drain in order 10,11,12,13, interleaved per the priority rules; no result is lost or duplicated.
- Scoreboard: iss_valid with iss_rd=3 → busy[3]=1 next cycle; ALU commit to rd=3 → busy[3]=0 on the edge that sets WE3. A same-edge iss_rd=3 together with that commit → busy[3] stays 1.
- x0: alu_valid=1, alu_rd=0, data=0x1234 → alu_ready=1, WE3 stays 0, busy unchanged. iss_valid with iss_rd=0 → busy stays 0.
- Async reset mid-operation: with 3 FIFO entries and busy=0x0000_0408, assert rst between edges → WE3=0 and busy=0 immediately. After release, fifo_full=0, lsu_ready=1, and no stale write appears on A3/WD3 with WE3=1.
